ram_init_loader: RTL
====================

# ram_init_loader

Power-up/re-load sequencer that sits between the SLC-3 CPU memory port and the on-chip 1-port RAM. After reset it streams a program image from a synchronous image ROM into the RAM and zero-fills the remainder. While it runs it owns the RAM port and stalls the CPU; afterwards it becomes a transparent pass-through of the CPU's address/data/read/write strobes. An optional read-back pass checks the loaded contents.

## Interface
Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 16, word width
- DEPTH, 1024, RAM words written per load (≤ 2^ADDR_W)
- IMG_LEN, 256, words taken from image ROM; addresses IMG_LEN..DEPTH-1 get 0

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  re-load request, sampled only in DONE
- cpu_addr  in  ADDR_W  CPU address
- cpu_data  in  DATA_W  CPU write data
- cpu_we, cpu_oe  in  1  CPU write / read strobes
- cpu_stall  out  1  high while loader owns RAM
- img_addr  out  ADDR_W  image ROM address
- img_data  in  DATA_W  image ROM data, valid 1 cycle after img_addr
- mem_addr  out  ADDR_W, mem_data  out  DATA_W, mem_wren  out  1, mem_rden  out  1  RAM port
- mem_q  in  DATA_W  RAM read data, valid 1 cycle after mem_addr/mem_rden
- init_done  out  1  load (and verify) finished
- init_err  out  1  sticky verify mismatch
- err_addr  out  ADDR_W  first mismatching address

## Operation
- States: LOAD, VERIFY (macro only), DONE. Reset → LOAD, counter=0.
- Reset values: cpu_stall=1, mem_wren=0, mem_rden=0, mem_addr=0, mem_data=0, img_addr=0, init_done=0, init_err=0, err_addr=0.
- LOAD: cycle k drives img_addr=k (k<IMG_LEN; else don't care, held at 0). Cycle k+1 drives registered mem_addr=k, mem_wren=1, mem_data=img_data if k<IMG_LEN else 0. Counter stops at DEPTH-1. After last write → VERIFY (macro) or DONE.
- VERIFY: cycle j drives mem_addr=j, mem_rden=1, img_addr=j. Cycle j+1 compares mem_q with expected (img_data if j<IMG_LEN else 0). First mismatch sets init_err, captures err_addr=j; later mismatches do not overwrite. After last compare → DONE.
- DONE: cpu_stall=0, init_done=1. mem_* = cpu_* combinationally (addr, data, wren=cpu_we, rden=cpu_oe).
- Start=1 in DONE: next cycle → LOAD, counter=0, init_done=0, init_err and err_addr cleared, cpu_stall=1. Start in LOAD/VERIFY ignored.
- While stalled: cpu_* ignored; mem_wren never asserted by CPU.
- Counter width ADDR_W+1 so DEPTH=2^ADDR_W terminates without wrap.

## Timing
- LOAD takes DEPTH+1 cycles (one ROM-latency bubble, then one write/cycle; mem_wren low in first cycle).
- VERIFY takes DEPTH+1 cycles; init_err asserts cycle after the failing compare read returns.
- From Reset_n rise to init_done=1: DEPTH+1 cycles (no macro), 2·DEPTH+2 (macro).
- Start accepted in DONE: cpu_stall high on the next edge; CPU strobes in the Start cycle still pass through.
- Reset_n low mid-LOAD/VERIFY: immediate abort, all outputs to reset values, load restarts from address 0 on release.

## Configuration
- RAM_INIT_VERIFY_EN defined: VERIFY state, init_err and err_addr live.
- Not defined: LOAD → DONE directly; init_err and err_addr tied 0; mem_rden low whenever stalled.

## Test plan
- Reset release, IMG_LEN=4, DEPTH=8, ROM={0x1234,0x5678,0x9ABC,0xDEF0} → writes addr 0..3 with those words, 4..7 with 0x0000, mem_wren high exactly 8 cycles, init_done at cycle 9.
- After DONE, cpu_addr=5, cpu_we=1, cpu_data=0xBEEF → same-cycle mem_addr=5, mem_wren=1, mem_data=0xBEEF; cpu_stall=0.
- During LOAD, cpu_we=1 held → mem_wren only on loader writes, mem_data never CPU value.
- Macro on, bench RAM model corrupts addr 2 to 0x0000 → init_err=1, err_addr=2, init_done=1 at cycle 18; a second corruption at addr 6 leaves err_addr=2.
- Start pulse in DONE → init_done falls next cycle, init_err clears, full reload repeats identically.
- Reset_n low at LOAD address 3 → all outputs reset immediately; on release load restarts at address 0 and completes normally.

Source files
------------

// File: rtl/ram_init_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_init_loader                                            |
// | Description : Power-up / re-load sequencer between the SLC-3 CPU memory  |
// |               port and the on-chip single-port RAM. After reset it       |
// |               copies IMG_LEN words from a synchronous image ROM into the |
// |               RAM, zero-fills addresses IMG_LEN..DEPTH-1 and stalls the  |
// |               CPU. Once done, the CPU strobes pass straight through to   |
// |               the RAM port.                                              |
// |                                                                          |
// | Optional    : `define RAM_INIT_VERIFY_EN adds a read-back pass that      |
// |               compares the RAM against the image and reports the first   |
// |               mismatching address. Without it init_err / err_addr are 0  |
// |               and mem_rden stays low while stalled.                      |
// |                                                                          |
// | Ports       : Clk, Reset_n (async, active low), Start (re-load, DONE)    |
// |               cpu_addr/cpu_data/cpu_we/cpu_oe -> CPU request             |
// |               cpu_stall                       -> loader owns the RAM     |
// |               img_addr / img_data             -> image ROM (1-cycle lat) |
// |               mem_addr/mem_data/mem_wren/mem_rden, mem_q -> RAM port     |
// |               init_done, init_err, err_addr   -> status                  |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ram_init_loader #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int IMG_LEN = 256
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_we,
    input  logic              cpu_oe,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q,
    output logic              init_done,
    output logic              init_err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [1:0] c_ST_LOAD   = 2'd0;
`ifdef RAM_INIT_VERIFY_EN
    localparam logic [1:0] c_ST_VERIFY = 2'd1;
`endif
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    // One extra counter bit so DEPTH == 2**ADDR_W is reachable without wrap.
    localparam logic [ADDR_W:0] c_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_IMG_LEN = (ADDR_W+1)'(IMG_LEN);

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_stall;
    logic              r_done;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_wren;
    logic              r_wr_img;    // current write takes img_data, else zero
    logic [ADDR_W-1:0] r_img_addr;

    logic [ADDR_W:0]   w_cnt_next;
    logic [ADDR_W-1:0] w_cnt_addr;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_cnt_next  = r_cnt + (ADDR_W+1)'(1);
    assign w_cnt_addr  = r_cnt[ADDR_W-1:0];
    assign w_next_addr = w_cnt_next[ADDR_W-1:0];

`ifdef RAM_INIT_VERIFY_EN
    logic              r_rden;
    logic              r_chk_valid;   // a read issued last cycle returns now
    logic              r_chk_img;     // that read targets an image address
    logic [ADDR_W-1:0] r_chk_addr;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
    logic [DATA_W-1:0] w_expect;
    logic              w_mismatch;

    // ROM was addressed alongside the RAM read, so both answer this cycle.
    assign w_expect   = r_chk_img ? img_data : '0;
    assign w_mismatch = r_chk_valid && (mem_q != w_expect);
`else
    logic w_unused_mem_q;
    assign w_unused_mem_q = ^mem_q;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= c_ST_LOAD;
            r_cnt       <= '0;
            r_stall     <= 1'b1;
            r_done      <= 1'b0;
            r_mem_addr  <= '0;
            r_wren      <= 1'b0;
            r_wr_img    <= 1'b0;
            r_img_addr  <= '0;
`ifdef RAM_INIT_VERIFY_EN
            r_rden      <= 1'b0;
            r_chk_valid <= 1'b0;
            r_chk_img   <= 1'b0;
            r_chk_addr  <= '0;
            r_err       <= 1'b0;
            r_err_addr  <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (r_cnt < c_DEPTH) begin
                        // Write the word whose ROM read was issued last cycle.
                        r_mem_addr <= w_cnt_addr;
                        r_wren     <= 1'b1;
                        r_wr_img   <= (r_cnt < c_IMG_LEN);
                        r_img_addr <= (w_cnt_next < c_IMG_LEN) ? w_next_addr : '0;
                        r_cnt      <= w_cnt_next;
                    end else begin
                        r_wren     <= 1'b0;
                        r_wr_img   <= 1'b0;
                        r_mem_addr <= '0;
                        r_img_addr <= '0;
                        r_cnt      <= '0;
`ifdef RAM_INIT_VERIFY_EN
                        r_state    <= c_ST_VERIFY;
                        r_rden     <= 1'b1;
`else
                        r_state    <= c_ST_DONE;
                        r_done     <= 1'b1;
                        r_stall    <= 1'b0;
`endif
                    end
                end

`ifdef RAM_INIT_VERIFY_EN
                c_ST_VERIFY: begin
                    r_chk_valid <= r_rden;
                    r_chk_addr  <= r_mem_addr;
                    r_chk_img   <= ({1'b0, r_mem_addr} < c_IMG_LEN);
                    // Sticky: only the first mismatch is recorded.
                    if (w_mismatch && !r_err) begin
                        r_err      <= 1'b1;
                        r_err_addr <= r_chk_addr;
                    end
                    if (w_cnt_next < c_DEPTH) begin
                        r_mem_addr <= w_next_addr;
                        r_img_addr <= w_next_addr;
                        r_rden     <= 1'b1;
                    end else begin
                        r_mem_addr <= '0;
                        r_img_addr <= '0;
                        r_rden     <= 1'b0;
                    end
                    if (r_cnt == c_DEPTH) begin
                        r_state     <= c_ST_DONE;
                        r_done      <= 1'b1;
                        r_stall     <= 1'b0;
                        r_chk_valid <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
`endif

                c_ST_DONE: begin
                    if (Start) begin
                        r_state    <= c_ST_LOAD;
                        r_cnt      <= '0;
                        r_done     <= 1'b0;
                        r_stall    <= 1'b1;
                        r_mem_addr <= '0;
                        r_wren     <= 1'b0;
                        r_wr_img   <= 1'b0;
                        r_img_addr <= '0;
`ifdef RAM_INIT_VERIFY_EN
                        r_rden     <= 1'b0;
                        r_err      <= 1'b0;
                        r_err_addr <= '0;
`endif
                    end
                end

                default: begin
                    r_state    <= c_ST_LOAD;
                    r_cnt      <= '0;
                    r_done     <= 1'b0;
                    r_stall    <= 1'b1;
                    r_mem_addr <= '0;
                    r_wren     <= 1'b0;
                    r_wr_img   <= 1'b0;
                    r_img_addr <= '0;
                end
            endcase
        end
    end

    assign cpu_stall = r_stall;
    assign init_done = r_done;
    assign img_addr  = r_img_addr;

    // In DONE the CPU drives the RAM directly, with no added latency.
    assign mem_addr = r_done ? cpu_addr : r_mem_addr;
    assign mem_data = r_done ? cpu_data : (r_wr_img ? img_data : '0);
    assign mem_wren = r_done ? cpu_we   : r_wren;

`ifdef RAM_INIT_VERIFY_EN
    assign mem_rden = r_done ? cpu_oe : r_rden;
    assign init_err = r_err;
    assign err_addr = r_err_addr;
`else
    assign mem_rden = r_done ? cpu_oe : 1'b0;
    assign init_err = 1'b0;
    assign err_addr = '0;
`endif

endmodule
`default_nettype wire
